// File: rtl/cis_pkg.sv
// -----------------------------------------------------------------------------
// cis_pkg
// Shared definitions for the CIS capture front-end:
//   - cis_state_t    : capture state machine encoding (IDLE, WAIT_VS, ACTIVE)
//   - ENTRY_*        : layout of one pixel FIFO entry, {sof, eol, data}, where
//                      the two marker bits sit directly above the pixel data.
//                      Offsets are relative to bit PIX_W of the entry.
// -----------------------------------------------------------------------------
package cis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } cis_state_t;

    // Marker bits stored above the pixel data in each FIFO entry
    localparam int ENTRY_EOL_OFS = 0;
    localparam int ENTRY_SOF_OFS = 1;
    localparam int ENTRY_META_W  = 2;

endpackage

// File: rtl/cis_pix_fifo.sv
// -----------------------------------------------------------------------------
// cis_pix_fifo
// Synchronous first-word-fall-through FIFO for captured pixel entries.
// The head entry is presented on pop_data whenever the FIFO is not empty and
// stays stable until it is popped. A push into a full FIFO is accepted only if
// a pop happens in the same cycle; otherwise it is dropped (the caller flags
// the overflow). flush empties the FIFO and takes priority over push/pop.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           discard all stored entries
//   push, push_data write request and entry
//   pop             consume head entry (ignored when empty)
//   pop_data        head entry (zero when empty)
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module cis_pix_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head entry is gated to zero while empty so the stream outputs idle at 0
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage array; no reset needed because reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers; a flush rewinds both to the same position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/cis_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cis_capture_ctrl
// Parallel CMOS image sensor capture front-end. The CIS pad bus is sampled in
// the wb_clk_i domain through a 2-FF synchroniser, PCLK rising edges are
// detected and registered, and pixels inside the programmable crop window are
// pushed into a FWFT FIFO that feeds a valid/ready pixel stream carrying
// start-of-frame and end-of-line markers.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   enable_i                    capture enable; low forces IDLE and flushes
//   cis_pclk_i/hsync_i/vsync_i  sensor pad controls (asynchronous)
//   cis_data_i                  sensor pixel data
//   x_start_i..y_end_i          inclusive crop window
//   ovf_clr_i                   clears the sticky overflow flag
//   m_valid_o/m_ready_i         pixel stream handshake
//   m_data_o, m_sof_o, m_eol_o  pixel and frame/line markers
//   frame_cnt_o                 completed frame count (wraps)
//   overflow_o                  sticky FIFO overflow
//   frame_irq_o                 one-cycle pulse per completed frame
//   busy_o                      state machine not idle
// -----------------------------------------------------------------------------
module cis_capture_ctrl #(
    parameter int PIX_W       = 10,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 12,
    parameter int VS_ACT_HIGH = 1,
    parameter int FCNT_W      = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              enable_i,
    input  logic              cis_pclk_i,
    input  logic              cis_hsync_i,
    input  logic              cis_vsync_i,
    input  logic [PIX_W-1:0]  cis_data_i,
    input  logic [CNT_W-1:0]  x_start_i,
    input  logic [CNT_W-1:0]  x_end_i,
    input  logic [CNT_W-1:0]  y_start_i,
    input  logic [CNT_W-1:0]  y_end_i,
    input  logic              ovf_clr_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [PIX_W-1:0]  m_data_o,
    output logic              m_sof_o,
    output logic              m_eol_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              overflow_o,
    output logic              frame_irq_o,
    output logic              busy_o
);

    import cis_pkg::*;

    localparam int ENTRY_W = PIX_W + ENTRY_META_W;

    // Synchroniser stages
    logic             pclk_s1, pclk_s2, pclk_d;
    logic             hs_s1, hs_s2;
    logic             vs_s1, vs_s2;
    logic [PIX_W-1:0] data_s1, data_s2;

    // Edge-detect stage, all aligned with the registered pixel strobe
    logic             stb_q;
    logic             hs_q, hs_qd;
    logic             vs_act_q, vs_act_qd;
    logic [PIX_W-1:0] data_q;

    logic             pix_stb;
    logic             vs_act_s2;
    logic             hs_fall, vs_rise, vs_fall;

    cis_state_t       state_q, state_d;
    logic             frame_start, frame_end;

    logic [CNT_W-1:0] col_q, line_q;
    logic             sof_pend_q;
    logic             in_win;
    logic             pix_push;
    logic [ENTRY_W-1:0] push_entry;

    logic             fifo_flush, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    assign pix_stb   = pclk_s2 & ~pclk_d;
    assign vs_act_s2 = (VS_ACT_HIGH != 0) ? vs_s2 : ~vs_s2;
    assign hs_fall   = ~hs_q & hs_qd;
    assign vs_rise   = vs_act_q & ~vs_act_qd;
    assign vs_fall   = ~vs_act_q & vs_act_qd;

    // Two-flop synchroniser on every pad signal plus a third PCLK flop for
    // rising-edge detection; data and HSYNC travel with PCLK so a pixel is
    // always paired with the data that was on the pads at its PCLK edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            pclk_s1 <= 1'b0;
            pclk_s2 <= 1'b0;
            pclk_d  <= 1'b0;
            hs_s1   <= 1'b0;
            hs_s2   <= 1'b0;
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            pclk_s1 <= cis_pclk_i;
            pclk_s2 <= pclk_s1;
            pclk_d  <= pclk_s2;
            hs_s1   <= cis_hsync_i;
            hs_s2   <= hs_s1;
            vs_s1   <= cis_vsync_i;
            vs_s2   <= vs_s1;
            data_s1 <= cis_data_i;
            data_s2 <= data_s1;
        end
    end

    // Registered edge stage: the pixel strobe, its data and the sync levels
    // are captured together so that crop decisions and sync edges are seen in
    // a consistent order one cycle after the synchroniser.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            stb_q     <= 1'b0;
            hs_q      <= 1'b0;
            hs_qd     <= 1'b0;
            vs_act_q  <= 1'b0;
            vs_act_qd <= 1'b0;
            data_q    <= '0;
        end else begin
            stb_q     <= pix_stb;
            hs_q      <= hs_s2;
            hs_qd     <= hs_q;
            vs_act_q  <= vs_act_s2;
            vs_act_qd <= vs_act_q;
            data_q    <= data_s2;
        end
    end

    // Capture state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Dropping enable wins over any frame edge, so a frame
    // interrupted by disable is never counted.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_VS;
                end
                WAIT_VS: begin
                    if (vs_rise) begin
                        state_d     = ACTIVE;
                        frame_start = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (vs_fall) begin
                        state_d   = WAIT_VS;
                        frame_end = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Crop window test and FIFO entry assembly. An empty window (start > end)
    // can never match, so no pixels are pushed while frames still count.
    always_comb begin
        in_win = (col_q >= x_start_i) && (col_q <= x_end_i) &&
                 (line_q >= y_start_i) && (line_q <= y_end_i);
        pix_push = (state_q == ACTIVE) && enable_i && stb_q && hs_q && in_win;
        push_entry = '0;
        push_entry[PIX_W-1:0]             = data_q;
        push_entry[PIX_W + ENTRY_EOL_OFS] = (col_q == x_end_i);
        push_entry[PIX_W + ENTRY_SOF_OFS] = sof_pend_q;
    end

    // Column/line counters and the pending start-of-frame flag. Counters
    // saturate rather than wrap so an oversized frame cannot alias back into
    // the crop window.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            col_q      <= '0;
            line_q     <= '0;
            sof_pend_q <= 1'b0;
        end else if (frame_start) begin
            col_q      <= '0;
            line_q     <= '0;
            sof_pend_q <= 1'b1;
        end else if ((state_q == ACTIVE) && enable_i) begin
            if (stb_q && hs_q) begin
                if (pix_push) begin
                    sof_pend_q <= 1'b0;
                end
                if (col_q != '1) begin
                    col_q <= col_q + CNT_W'(1);
                end
            end
            if (hs_fall) begin
                col_q <= '0;
                if (line_q != '1) begin
                    line_q <= line_q + CNT_W'(1);
                end
            end
        end
    end

    // Frame counter and end-of-frame interrupt pulse
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            frame_cnt_o <= '0;
            frame_irq_o <= 1'b0;
        end else begin
            frame_irq_o <= frame_end;
            if (frame_end) begin
                frame_cnt_o <= frame_cnt_o + FCNT_W'(1);
            end
        end
    end

    // Sticky overflow: a pixel dropped because the FIFO is full and nothing is
    // leaving this cycle. A new drop outranks a simultaneous clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            overflow_o <= 1'b0;
        end else if (pix_push && fifo_full && !fifo_pop) begin
            overflow_o <= 1'b1;
        end else if (ovf_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

    assign fifo_flush = !enable_i;
    assign fifo_pop   = m_valid_o && m_ready_i;

    cis_pix_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .flush     (fifo_flush),
        .push      (pix_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_valid_o = !fifo_empty;
    assign m_data_o  = fifo_head[PIX_W-1:0];
    assign m_eol_o   = fifo_head[PIX_W + ENTRY_EOL_OFS];
    assign m_sof_o   = fifo_head[PIX_W + ENTRY_SOF_OFS];
    assign busy_o    = (state_q != IDLE);

endmodule

// File: doc/cis_capture_ctrl.md
Name: cis_capture_ctrl

Overview:
Parametrised parallel CMOS-image-sensor capture front-end for the ISP user project. It samples the CIS pad bus (data, PCLK, HSYNC, VSYNC) in the wb_clk_i domain and crops a programmable window. Captured pixels are buffered in a FIFO and emitted as a valid/ready pixel stream with start-of-frame and end-of-line markers. Successor to the fixed 10-bit CIS hookup: pixel width, FIFO depth, counter width and sync polarity are generic, and it adds crop, overflow detection and frame interrupts.

Parameters:
PIX_W, 10, pixel data width (CIS D[PIX_W-1:0])
FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4
CNT_W, 12, width of the column, line and crop counters
VS_ACT_HIGH, 1, 1 = VSYNC active-high, 0 = active-low
FCNT_W, 16, frame counter width

Ports:
wb_clk_i  in  1  system clock; sole clock
wb_rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  capture enable (level)
cis_pclk_i  in  1  sensor pixel clock from pad (sampled as data)
cis_hsync_i  in  1  line valid, active-high
cis_vsync_i  in  1  frame sync, polarity per VS_ACT_HIGH
cis_data_i  in  PIX_W  pixel data
x_start_i, x_end_i  in  CNT_W  inclusive crop columns
y_start_i, y_end_i  in  CNT_W  inclusive crop lines
ovf_clr_i  in  1  clears overflow_o
m_valid_o  out  1  stream valid
m_ready_i  in  1  stream ready
m_data_o  out  PIX_W  pixel
m_sof_o  out  1  first cropped pixel of frame
m_eol_o  out  1  last cropped pixel of line (col == x_end)
frame_cnt_o  out  FCNT_W  completed frames
overflow_o  out  1  sticky FIFO overflow
frame_irq_o  out  1  one-cycle pulse at frame end
busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; sync flops 0.
- Pad inputs pass through a 2-FF synchroniser; a third PCLK flop gives edge detect. pix_stb is asserted when the synced PCLK is 1 and its delayed copy is 0. Data and HSYNC are taken from the same synchroniser stage as PCLK.
- State machine:
  - IDLE -> WAIT_VS when enable_i = 1.
  - WAIT_VS -> ACTIVE on VSYNC inactive-to-active edge; clears column and line counters; sets sof_pend.
  - ACTIVE -> WAIT_VS on VSYNC active-to-inactive edge. This is frame end: frame_cnt++ (wraps) and frame_irq_o pulses for one cycle.
  - Any state -> IDLE when enable_i = 0, at the next edge. FIFO is flushed; a partial frame is not counted.
- ACTIVE counting:
  - On pix_stb with HSYNC = 1: if x_start <= col <= x_end and y_start <= line <= y_end, push {sof_pend, col == x_end, data}, then col++. The first push clears sof_pend.
  - HSYNC falling edge: col = 0, line++.
  - Counters saturate at all-ones and do not wrap.
  - If x_start > x_end or y_start > y_end, nothing is pushed and frames are still counted.
- FIFO:
  - Entry width PIX_W+2.
  - Push when full: pixel dropped, overflow_o set. overflow_o is cleared by ovf_clr_i. If a set and a clear occur in the same cycle, set wins.
  - Simultaneous push and pop when full: both succeed, no overflow.
- Output: first-word-fall-through. m_valid_o = !empty. A pop happens when m_valid_o & m_ready_i. m_data_o, m_sof_o and m_eol_o are stable while m_valid_o = 1 and m_ready_i = 0.
- Latency: with the FIFO empty and m_ready_i = 1, m_valid_o rises 4 wb_clk_i cycles after the pad PCLK rising edge (2 sync + edge + write).
- PCLK must be at most wb_clk_i/4. Faster PCLK is unsupported; no detection is required.

Decomposition:
- Shared package cis_pkg: state enum (IDLE, WAIT_VS, ACTIVE) and the FIFO entry field offsets (SOF bit, EOL bit).
- Sub-module cis_pix_fifo: parametrised synchronous FWFT FIFO (WIDTH, DEPTH) with full, empty and a flush input.
- Synchroniser and crop logic stay in the top module.

Test Plan:
- Reset/enable: hold wb_rst_n_i = 0 -> all outputs 0. Release with enable_i = 0 -> busy_o = 0. Set enable_i = 1 -> busy_o = 1 after one cycle.
- Full frame: crop 0..3 x 0..1, frame 4 px x 2 lines, data 0x001..0x008, m_ready_i = 1 -> 8 beats in order; m_sof_o on 0x001; m_eol_o on 0x004 and 0x008; frame_cnt_o = 1; one frame_irq_o pulse.
- Crop window: 8x4 frame, crop x 2..5, y 1..2 -> exactly 8 beats, covering pixels (2..5, 1..2); m_sof_o on (2,1).
- Backpressure/overflow: FIFO_DEPTH = 16, m_ready_i = 0, 20 in-window pixels -> 16 stored, overflow_o = 1. Then m_ready_i = 1 -> 16 beats with the first 16 values. ovf_clr_i -> overflow_o = 0.
- Abort: drop enable_i mid-line after 3 pixels -> IDLE, m_valid_o = 0 next cycle, frame_cnt_o unchanged.
- Polarity/wrap: VS_ACT_HIGH = 0, FCNT_W = 2, 5 frames -> frame_cnt_o = 1 and 5 irq pulses.
